// File: rtl/and2.sv
// and2: bitwise AND gate with registered copy, per-bit rise pulses and optional AND2_STATS_EN hi_count
module and2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] y_rise,
  output logic [CNT_W-1:0] hi_count
);
  assign y = a & b;
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      y_rise <= '0;
    end else begin
      y_q    <= y;
      y_rise <= y & ~y_q;
    end
  end
`ifdef AND2_STATS_EN
  always_ff @(posedge clk)
    hi_count <= rst ? '0 : (|y && !(&hi_count)) ? hi_count + CNT_W'(1) : hi_count;
`else
  assign hi_count = '0;
`endif
endmodule

// File: tb/tb_and2.sv
// tb_and2: randomized scoreboard bench for and2 at WIDTH=4, CNT_W=4
module tb_and2;
  localparam int W  = 4;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  y, y_q, y_rise;
  logic [CW-1:0] hi_count;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] yq;
    logic [W-1:0] yr;
    int           cnt;
  } exp_t;
  exp_t q[$];
  bit   last_hi[W];
  int   m_cnt = 0;
  and2 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .y(y), .y_q(y_q), .y_rise(y_rise), .hi_count(hi_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", n, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic [W-1:0] na, input logic [W-1:0] nb);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r;
    a   = na;
    b   = nb;
    #1;
    chk("y_comb", 32'(y), 32'(na & nb));
    @(posedge clk);
    e.y  = '0;
    e.yq = '0;
    e.yr = '0;
    for (int i = 0; i < W; i++) begin
      e.y[i] = na[i] && nb[i];
      if (!r) begin
        e.yq[i] = e.y[i];
        e.yr[i] = e.y[i] && !last_hi[i];
      end
      last_hi[i] = r ? 1'b0 : e.y[i];
    end
    if (r) m_cnt = 0;
    else if (e.y != 0 && m_cnt < (2 ** CW) - 1) m_cnt = m_cnt + 1;
`ifdef AND2_STATS_EN
    e.cnt = m_cnt;
`else
    e.cnt = 0;
`endif
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("y_q", 32'(y_q), 32'(e.yq));
        chk("y_rise", 32'(y_rise), 32'(e.yr));
        chk("hi_count", 32'(hi_count), 32'(e.cnt));
      end
    end
  end
  initial begin
    for (int i = 0; i < W; i++) last_hi[i] = 1'b0;
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, W'((i >> 1) & 1), W'(i & 1));
    step(1'b0, 4'hf, 4'hf);
    step(1'b0, 4'hf, 4'hf);
    step(1'b0, 4'hf, 4'hf);
    step(1'b1, 4'hf, 4'hf);
    step(1'b0, 4'hf, 4'hf);
    step(1'b0, 4'hf, 4'hf);
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'hc, 4'ha);
    step(1'b0, 4'hc, 4'he);
    step(1'b0, 4'hc, 4'he);
    step(1'b0, 4'h5, 4'hf);
    step(1'b0, 4'h0, 4'hf);
    step(1'b0, 4'h5, 4'hf);
    for (int i = 0; i < 20; i++) step(1'b0, 4'hf, 4'hf);
    step(1'b1, 4'hf, 4'hf);
    step(1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 15) == 0, W'($urandom), W'($urandom));
    repeat (3) @(negedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
